// File: rtl/mux_pkg.sv
// Shared constants and helpers for the mux_N_to_1 / demux_1_to_n_reg family.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mux_pkg;

  // Default widths shared across the selector family
  localparam int DEF_BIT_WIDTH = 16;
  localparam int DEF_SEL_WIDTH = 2;

  // Per-lane one-entry slot occupancy
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Ceiling log2 for sizing select fields from lane counts
  function automatic int clog2(input int value);
    int v;
    int r;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry registered holding slot for a single demux output lane.
// Latency: a write appears on o_data/o_full the cycle after i_wr_en.
// Backpressure: holds its word until i_rd_ready; the parent only writes when empty or draining.
module demux_slot
  import mux_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wr_en,
  input  logic [BIT_WIDTH-1:0] i_wr_data,
  input  logic                 i_rd_ready,
  output logic                 o_full,
  output logic [BIT_WIDTH-1:0] o_data
);

  slot_state_e          r_state;
  logic [BIT_WIDTH-1:0] r_data;

  // Slot occupancy and data: a write wins over a drain so same-edge drain+refill stays full
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= SLOT_EMPTY;
      r_data  <= '0;
    end else if (i_wr_en) begin
      r_state <= SLOT_FULL;
      r_data  <= i_wr_data;
    end else if ((r_state == SLOT_FULL) && i_rd_ready) begin
      // Data is left in place after a drain; consumers qualify with o_full
      r_state <= SLOT_EMPTY;
    end
  end

  assign o_full = (r_state == SLOT_FULL);
  assign o_data = r_data;

endmodule

// File: rtl/demux_1_to_n_reg.sv
// Registered 1-to-N demux: routes one input word per cycle to the lane picked by i_sel.
// Latency: 1 cycle from accepted input to o_valid/o_B of the target lane.
// Backpressure: o_ready drops only when the target lane (all lanes for broadcast) is full and not draining.
// Optional feature macro: DEMUX_BCAST_EN adds i_bcast, writing one word into every lane at once.
module demux_1_to_n_reg
  import mux_pkg::*;
#(
  parameter  int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter  int SEL_WIDTH = DEF_SEL_WIDTH,
  localparam int NUM_OUT   = 1 << SEL_WIDTH
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [SEL_WIDTH-1:0]         i_sel,
  input  logic [BIT_WIDTH-1:0]         i_A,
`ifdef DEMUX_BCAST_EN
  input  logic                         i_bcast,
`endif
  output logic [NUM_OUT-1:0]           o_valid,
  input  logic [NUM_OUT-1:0]           i_ready,
  output logic [NUM_OUT*BIT_WIDTH-1:0] o_B,
  output logic                         o_busy
);

  logic [NUM_OUT-1:0] w_full;
  logic [NUM_OUT-1:0] w_slot_ok;
  logic [NUM_OUT-1:0] w_wr_en;
  logic               w_tgt_ok;
  logic               w_xfer;

  // A lane can take a word if it is empty or being drained this same edge
  assign w_slot_ok = ~w_full | i_ready;

`ifdef DEMUX_BCAST_EN
  // Broadcast needs every lane able to accept; the select is ignored
  assign w_tgt_ok = i_bcast ? (&w_slot_ok) : w_slot_ok[i_sel];
`else
  assign w_tgt_ok = w_slot_ok[i_sel];
`endif

  assign o_ready = !i_reset && w_tgt_ok;
  assign w_xfer  = i_valid && o_ready;

  genvar g;
  generate
    for (g = 0; g < NUM_OUT; g++) begin : g_lane
`ifdef DEMUX_BCAST_EN
      assign w_wr_en[g] = w_xfer && (i_bcast || (i_sel == SEL_WIDTH'(g)));
`else
      assign w_wr_en[g] = w_xfer && (i_sel == SEL_WIDTH'(g));
`endif

      demux_slot #(
        .BIT_WIDTH (BIT_WIDTH)
      ) u_slot (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_wr_en    (w_wr_en[g]),
        .i_wr_data  (i_A),
        .i_rd_ready (i_ready[g]),
        .o_full     (w_full[g]),
        .o_data     (o_B[g*BIT_WIDTH +: BIT_WIDTH])
      );
    end
  endgenerate

  assign o_valid = w_full;
  assign o_busy  = |w_full;

endmodule

// File: tb/tb_demux_1_to_n_reg.sv
// Self-checking bench for demux_1_to_n_reg: directed vector table, corner sequences, random vs lane model.
// Latency: checks outputs 1 ns after each rising edge, o_ready 1 ns after inputs change.
// Backpressure: random per-lane i_ready patterns; broadcast cases only when DEMUX_BCAST_EN is defined.
module tb_demux_1_to_n_reg;

  localparam int BW = 16;
  localparam int SW = 2;
  localparam int NO = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            vld;
  logic            rdy_o;
  logic [SW-1:0]   sel;
  logic [BW-1:0]   a;
  logic [NO-1:0]   ovld;
  logic [NO-1:0]   rdy_i;
  logic [NO*BW-1:0] ob;
  logic            busy;
`ifdef DEMUX_BCAST_EN
  logic            bc;
`endif

  always #5 clk = ~clk;

  demux_1_to_n_reg #(
    .BIT_WIDTH (BW),
    .SEL_WIDTH (SW)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_valid (vld),
    .o_ready (rdy_o),
    .i_sel   (sel),
    .i_A     (a),
`ifdef DEMUX_BCAST_EN
    .i_bcast (bc),
`endif
    .o_valid (ovld),
    .i_ready (rdy_i),
    .o_B     (ob),
    .o_busy  (busy)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference: each lane holds at most one word; last written word persists after a drain
  logic          m_full [NO];
  logic [BW-1:0] m_data [NO];
  logic          m_ready;
  logic          smp_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic model_ready(input logic r, input logic b,
                                       input logic [SW-1:0] s, input logic [NO-1:0] rd);
    int ok;
    if (r) return 1'b0;
    if (b) begin
      ok = 1;
      for (int k = 0; k < NO; k++) if (m_full[k] && !rd[k]) ok = 0;
      return (ok == 1);
    end
    return !m_full[s] || rd[s];
  endfunction

  function automatic logic [NO-1:0] model_vld();
    logic [NO-1:0] v;
    for (int k = 0; k < NO; k++) v[k] = m_full[k];
    return v;
  endfunction

  function automatic logic [NO*BW-1:0] model_ob();
    logic [NO*BW-1:0] o;
    for (int k = 0; k < NO; k++) o[k*BW +: BW] = m_data[k];
    return o;
  endfunction

  // Drive one cycle of inputs, sample o_ready, clock the DUT and the model together
  task automatic apply(input logic r, input logic v, input logic [SW-1:0] s,
                       input logic [BW-1:0] d, input logic b, input logic [NO-1:0] rd);
    logic take;
    rst = r; vld = v; sel = s; a = d; rdy_i = rd;
`ifdef DEMUX_BCAST_EN
    bc = b;
`endif
    #1;
    smp_ready = rdy_o;
    m_ready   = model_ready(r, b, s, rd);
    take      = v && m_ready;
    @(posedge clk);
    for (int k = 0; k < NO; k++) begin
      if (r) begin
        m_full[k] = 1'b0;
        m_data[k] = '0;
      end else if (take && (b || (int'(s) == k))) begin
        m_full[k] = 1'b1;
        m_data[k] = d;
      end else if (m_full[k] && rd[k]) begin
        m_full[k] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " ready"}, 64'(smp_ready), 64'(m_ready));
    chk({tag, " valid"}, 64'(ovld), 64'(model_vld()));
    chk({tag, " data"},  64'(ob),   64'(model_ob()));
    chk({tag, " busy"},  64'(busy), 64'(|model_vld()));
  endtask

  typedef struct {
    logic          v;
    logic [SW-1:0] s;
    logic [BW-1:0] d;
    logic [NO-1:0] rd;
    logic          e_rdy;
    logic [NO-1:0] e_vld;
    logic [SW-1:0] e_lane;
    logic [BW-1:0] e_word;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic          r_r, r_v, r_b;
    logic [SW-1:0] r_s;
    logic [BW-1:0] r_d;
    logic [NO-1:0] r_rd;

    tbl[0] = '{1'b1, 2'd2, 16'hBEEF, 4'b0000, 1'b1, 4'b0100, 2'd2, 16'hBEEF};
    tbl[1] = '{1'b1, 2'd1, 16'h1111, 4'b0000, 1'b1, 4'b0110, 2'd1, 16'h1111};
    tbl[2] = '{1'b1, 2'd1, 16'h2222, 4'b0000, 1'b0, 4'b0110, 2'd1, 16'h1111};
    tbl[3] = '{1'b1, 2'd3, 16'h3333, 4'b0000, 1'b1, 4'b1110, 2'd3, 16'h3333};
    tbl[4] = '{1'b1, 2'd0, 16'h0001, 4'b0000, 1'b1, 4'b1111, 2'd0, 16'h0001};
    tbl[5] = '{1'b1, 2'd0, 16'h0002, 4'b0001, 1'b1, 4'b1111, 2'd0, 16'h0002};
    tbl[6] = '{1'b0, 2'd0, 16'hDEAD, 4'b1110, 1'b0, 4'b0001, 2'd1, 16'h1111};
    tbl[7] = '{1'b0, 2'd1, 16'h0000, 4'b0001, 1'b1, 4'b0000, 2'd0, 16'h0002};

    for (int k = 0; k < NO; k++) begin
      m_full[k] = 1'b0;
      m_data[k] = '0;
    end

    // Reset: o_ready low during reset, all slots empty and zeroed afterwards
    apply(1'b1, 1'b1, 2'd0, 16'h5A5A, 1'b0, 4'b0000);
    chk("reset ready", 64'(smp_ready), 64'd0);
    chk("reset valid", 64'(ovld), 64'd0);
    chk("reset data",  64'(ob),   64'd0);
    chk("reset busy",  64'(busy), 64'd0);

    // Directed vector table: routing, lane backpressure, drain+refill, data kept after drain
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, tbl[i].v, tbl[i].s, tbl[i].d, 1'b0, tbl[i].rd);
      chk($sformatf("tbl%0d ready", i), 64'(smp_ready), 64'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d valid", i), 64'(ovld), 64'(tbl[i].e_vld));
      chk($sformatf("tbl%0d word", i), 64'(ob[int'(tbl[i].e_lane)*BW +: BW]), 64'(tbl[i].e_word));
      chk($sformatf("tbl%0d busy", i), 64'(busy), 64'(|tbl[i].e_vld));
    end

    // Back-to-back words into one lane while its consumer drains every cycle
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b1, 2'd0, 16'hA000 + 16'(i), 1'b0, 4'b0001);
      chk($sformatf("b2b%0d ready", i), 64'(smp_ready), 64'd1);
      chk($sformatf("b2b%0d valid0", i), 64'(ovld[0]), 64'd1);
      chk($sformatf("b2b%0d word", i), 64'(ob[BW-1:0]), 64'(16'hA000 + 16'(i)));
    end
    apply(1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 4'b0001);
    chk("b2b drained", 64'(ovld), 64'd0);

    // Mid-operation reset drops all held words
    for (int k = 0; k < NO; k++) apply(1'b0, 1'b1, 2'(k), 16'hC000 + 16'(k), 1'b0, 4'b0000);
    chk("fill valid", 64'(ovld), 64'hF);
    chk("fill data", 64'(ob), 64'hC003_C002_C001_C000);
    apply(1'b1, 1'b1, 2'd0, 16'hFFFF, 1'b0, 4'b0000);
    chk("midrst ready", 64'(smp_ready), 64'd0);
    chk("midrst valid", 64'(ovld), 64'd0);
    chk("midrst data", 64'(ob), 64'd0);
    apply(1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 4'b0000);
    chk("postrst ready", 64'(smp_ready), 64'd1);

`ifdef DEMUX_BCAST_EN
    // Broadcast into empty lanes
    apply(1'b0, 1'b1, 2'd2, 16'h1234, 1'b1, 4'b0000);
    chk("bc ready", 64'(smp_ready), 64'd1);
    chk("bc valid", 64'(ovld), 64'hF);
    chk("bc data", 64'(ob), 64'h1234_1234_1234_1234);
    // Broadcast blocked by one full, stalled lane
    apply(1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 4'b1111);
    apply(1'b0, 1'b1, 2'd3, 16'h5555, 1'b0, 4'b0000);
    apply(1'b0, 1'b1, 2'd0, 16'h7777, 1'b1, 4'b0000);
    chk("bcblk ready", 64'(smp_ready), 64'd0);
    chk("bcblk valid", 64'(ovld), 64'h8);
    chk("bcblk lane3", 64'(ob[3*BW +: BW]), 64'h5555);
    apply(1'b0, 1'b1, 2'd0, 16'h7777, 1'b1, 4'b1000);
    chk("bcrel ready", 64'(smp_ready), 64'd1);
    chk("bcrel valid", 64'(ovld), 64'hF);
    chk("bcrel data", 64'(ob), 64'h7777_7777_7777_7777);
`endif

    // Random traffic against the lane model
    for (int i = 0; i < 600; i++) begin
      r_r  = ($urandom_range(99) == 0);
      r_v  = ($urandom_range(3) != 0);
      r_s  = SW'($urandom);
      r_d  = BW'($urandom);
      r_rd = NO'($urandom);
`ifdef DEMUX_BCAST_EN
      r_b  = ($urandom_range(7) == 0);
`else
      r_b  = 1'b0;
`endif
      apply(r_r, r_v, r_s, r_d, r_b, r_rd);
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
